// File: rtl/id_link_pkg.sv
// rtl/id_link_pkg.sv - shared constants, field positions and state encoding for the ID link
package id_link_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hBEAF;
  localparam logic [1:0]  TAG_REQ   = 2'b11;
  localparam logic [1:0]  TAG_ACK   = 2'b10;

  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 30;
  localparam int PWR_MSB  = 29;
  localparam int PWR_LSB  = 26;
  localparam int SND_MSB  = 25;
  localparam int SND_LSB  = 21;
  localparam int ASG_MSB  = 20;
  localparam int ASG_LSB  = 16;
  localparam int SYNC_MSB = 15;
  localparam int SYNC_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_ACK    = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/id_frame_check.sv
// rtl/id_frame_check.sv - combinational decode of a request word into fields and validity flags
module id_frame_check
  import id_link_pkg::*;
(
  input  logic [31:0] i_data,
  output logic [3:0]  o_power,
  output logic [4:0]  o_sender,
  output logic [4:0]  o_assigned,
  output logic        o_candidate,
  output logic        o_well_formed
);

  logic [1:0] w_tag;

  assign w_tag       = i_data[TAG_MSB:TAG_LSB];
  assign o_power     = i_data[PWR_MSB:PWR_LSB];
  assign o_sender    = i_data[SND_MSB:SND_LSB];
  assign o_assigned  = i_data[ASG_MSB:ASG_LSB];
  assign o_candidate = (i_data[SYNC_MSB:SYNC_LSB] == SYNC_WORD);

  // ID 0 is reserved, so sender 31 wrapping to 0 is rejected by the nonzero test
  assign o_well_formed = o_candidate && (w_tag == TAG_REQ) &&
                         (o_assigned != 5'd0) &&
                         (o_assigned == o_sender + 5'd1);

endmodule

// File: rtl/id_responder.sv
// rtl/id_responder.sv - accepts one layer-ID request, acknowledges it, then locks until reset
module id_responder
  import id_link_pkg::*;
#(
  parameter int ACK_HOLD = 4,
  parameter int ERR_SAT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [3:0]  min_power,
  output logic [31:0] ack_out,
  output logic        ack_valid,
  output logic [4:0]  chip_id,
  output logic [3:0]  power_level,
  output logic        id_valid,
  output logic [3:0]  bad_cnt,
  output logic [3:0]  rej_cnt
);

  localparam logic [3:0] SAT_LIM   = 4'(ERR_SAT);
  localparam logic [3:0] HOLD_LAST = 4'(ACK_HOLD - 1);

  logic [3:0] w_power;
  logic [4:0] w_sender;
  logic [4:0] w_assigned;
  logic       w_candidate;
  logic       w_well_formed;

  state_t      r_state;
  logic [3:0]  r_pwr;
  logic [4:0]  r_snd;
  logic [4:0]  r_asg;
  logic [3:0]  r_hold;
  logic [31:0] r_ack_out;
  logic        r_ack_valid;
  logic [4:0]  r_chip_id;
  logic [3:0]  r_power_level;
  logic        r_id_valid;
  logic [3:0]  r_bad_cnt;
  logic [3:0]  r_rej_cnt;

  id_frame_check u_frame_check (
    .i_data        (data_in),
    .o_power       (w_power),
    .o_sender      (w_sender),
    .o_assigned    (w_assigned),
    .o_candidate   (w_candidate),
    .o_well_formed (w_well_formed)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pwr         <= 4'd0;
      r_snd         <= 5'd0;
      r_asg         <= 5'd0;
      r_hold        <= 4'd0;
      r_ack_out     <= 32'd0;
      r_ack_valid   <= 1'b0;
      r_chip_id     <= 5'd0;
      r_power_level <= 4'd0;
      r_id_valid    <= 1'b0;
      r_bad_cnt     <= 4'd0;
      r_rej_cnt     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_well_formed) begin
            r_pwr   <= w_power;
            r_snd   <= w_sender;
            r_asg   <= w_assigned;
            r_state <= ST_CHECK;
          end else if (w_candidate) begin
            r_bad_cnt <= sat_inc(r_bad_cnt, SAT_LIM);
          end
        end
        ST_CHECK: begin
          // Outputs are loaded here so ack_valid rises on the first ACK cycle
          if (r_pwr >= min_power) begin
            r_ack_valid   <= 1'b1;
            r_ack_out     <= {TAG_ACK, r_pwr, r_asg, r_snd, SYNC_WORD};
            r_chip_id     <= r_asg;
            r_power_level <= r_pwr;
            r_hold        <= 4'd0;
            r_state       <= ST_ACK;
          end else begin
            r_rej_cnt <= sat_inc(r_rej_cnt, SAT_LIM);
            r_state   <= ST_IDLE;
          end
        end
        ST_ACK: begin
          if (r_hold == HOLD_LAST) begin
            r_ack_valid <= 1'b0;
            r_ack_out   <= 32'd0;
            r_id_valid  <= 1'b1;
            r_state     <= ST_LOCKED;
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        ST_LOCKED: begin
          r_state <= ST_LOCKED;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_out     = r_ack_out;
  assign ack_valid   = r_ack_valid;
  assign chip_id     = r_chip_id;
  assign power_level = r_power_level;
  assign id_valid    = r_id_valid;
  assign bad_cnt     = r_bad_cnt;
  assign rej_cnt     = r_rej_cnt;

endmodule

// File: tb/tb_id_responder.sv
// tb/tb_id_responder.sv - scoreboard bench for id_responder
module tb_id_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [3:0]  min_power = 4'd0;
  logic [31:0] ack_out;
  logic        ack_valid;
  logic [4:0]  chip_id;
  logic [3:0]  power_level;
  logic        id_valid;
  logic [3:0]  bad_cnt;
  logic [3:0]  rej_cnt;

  id_responder #(.ACK_HOLD(4), .ERR_SAT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .min_power   (min_power),
    .ack_out     (ack_out),
    .ack_valid   (ack_valid),
    .chip_id     (chip_id),
    .power_level (power_level),
    .id_valid    (id_valid),
    .bad_cnt     (bad_cnt),
    .rej_cnt     (rej_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] frame;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle with ack_valid high must match the next queued frame and cycle number
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack_out %h at cycle %0d, expected no ack", ack_out, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_frame", ack_out, mon_e.frame);
          chk("ack_cycle", cyc, mon_e.cycle);
        end
      end else if (ack_out !== 32'd0) begin
        chk("ack_out_idle", ack_out, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] w, output int n);
    data_in = w;
    n = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ack(input logic [31:0] f, input int n, input int cnt);
    exp_t e;
    for (int k = 0; k < cnt; k++) begin
      e.frame = f;
      e.cycle = n + 2 + k;
      sb.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack_out"}, ack_out, 32'd0);
    chk({tag, "_ack_valid"}, {31'd0, ack_valid}, 32'd0);
    chk({tag, "_chip_id"}, {27'd0, chip_id}, 32'd0);
    chk({tag, "_power_level"}, {28'd0, power_level}, 32'd0);
    chk({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_bad_cnt"}, {28'd0, bad_cnt}, 32'd0);
    chk({tag, "_rej_cnt"}, {28'd0, rej_cnt}, 32'd0);
  endtask

  initial begin
    int n;
    int n0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // power 0, sender 5, assigned 2: ID mismatch
    send(32'hC0A2BEAF, n);
    send(32'h0, n);
    chk("mismatch_bad_cnt", {28'd0, bad_cnt}, 32'd1);
    chk("mismatch_rej_cnt", {28'd0, rej_cnt}, 32'd0);

    // non-candidate word, then power 1 < min_power 3
    min_power = 4'd3;
    send(32'hC4221EAF, n);
    chk("noncand_bad_cnt", {28'd0, bad_cnt}, 32'd1);
    send(32'hC4A6BEAF, n);
    send(32'h0, n);
    chk("lowpwr_rej_cnt", {28'd0, rej_cnt}, 32'd1);
    chk("lowpwr_bad_cnt", {28'd0, bad_cnt}, 32'd1);
    chk("lowpwr_id_valid", {31'd0, id_valid}, 32'd0);

    // power 3, sender 5, assigned 6 -> {10,0011,00110,00101,BEAF}
    send(32'hCCA6BEAF, n0);
    push_ack(32'h8CC5BEAF, n0, 4);
    repeat (5) send(32'hC0A2BEAF, n);
    chk("lock_id_valid", {31'd0, id_valid}, 32'd1);
    chk("lock_chip_id", {27'd0, chip_id}, 32'd6);
    chk("lock_power_level", {28'd0, power_level}, 32'd3);
    chk("busy_bad_cnt", {28'd0, bad_cnt}, 32'd1);
    chk("busy_rej_cnt", {28'd0, rej_cnt}, 32'd1);

    // LOCKED ignores everything
    send(32'hCCA6BEAF, n);
    send(32'hC0A2BEAF, n);
    send(32'hC4A6BEAF, n);
    send(32'hC001BEAF, n);
    send(32'h0, n);
    send(32'h0, n);
    chk("locked_chip_id", {27'd0, chip_id}, 32'd6);
    chk("locked_power_level", {28'd0, power_level}, 32'd3);
    chk("locked_bad_cnt", {28'd0, bad_cnt}, 32'd1);
    chk("locked_rej_cnt", {28'd0, rej_cnt}, 32'd1);
    chk("locked_id_valid", {31'd0, id_valid}, 32'd1);

    rst_n = 1'b0;
    send(32'h0, n);
    check_zero("locked_reset");
    rst_n = 1'b1;

    // 16 mismatched frames plus sender 31 / assigned 0
    for (int i = 0; i < 16; i++) send(32'hC0A2BEAF, n);
    send(32'hC3E0BEAF, n);
    send(32'h0, n);
    chk("sat_bad_cnt", {28'd0, bad_cnt}, 32'd15);
    chk("sat_rej_cnt", {28'd0, rej_cnt}, 32'd0);

    // power 0 accepted with min_power 0; reset after two ack cycles
    min_power = 4'd0;
    send(32'hC001BEAF, n0);
    push_ack(32'h8020BEAF, n0, 2);
    send(32'h0, n);
    send(32'h0, n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_zero("ack_reset");
    rst_n = 1'b1;

    // resume from IDLE after reset
    send(32'hC001BEAF, n0);
    push_ack(32'h8020BEAF, n0, 4);
    repeat (6) send(32'h0, n);
    chk("resume_id_valid", {31'd0, id_valid}, 32'd1);
    chk("resume_chip_id", {27'd0, chip_id}, 32'd1);
    chk("resume_power_level", {28'd0, power_level}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
